// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the M-stage data port and data memory.
// Stores enter a small FIFO in one cycle and drain over a req/ack handshake;
// loads are answered combinationally with youngest-match forwarding.
module dmem_store_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DMEMDEPTH = 14,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTRBITS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     cpu_addr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    input  logic                 cpu_memwrite,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 mem_req,
    output logic [DMEMDEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic                 mem_ack,
    output logic [DMEMDEPTH-1:0] mem_raddr,
    input  logic [WIDTH-1:0]     mem_rdata
);

    localparam int unsigned CNTBITS = PTRBITS + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [PTRBITS-1:0]   head_q, head_d;
    logic [PTRBITS-1:0]   tail_q, tail_d;
    logic [CNTBITS-1:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DMEMDEPTH-1:0] idx_q [DEPTH];
    logic [DMEMDEPTH-1:0] idx_d [DEPTH];
    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [WIDTH-1:0]     data_d [DEPTH];

    logic [DMEMDEPTH-1:0] cpu_widx;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 unused_addr_bits;

    // Word index of the current access; byte offset and high bits are ignored
    assign cpu_widx         = cpu_addr[DMEMDEPTH+1:2];
    assign unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[WIDTH-1:DMEMDEPTH+2]};

    // Status flags and memory-side head view, all from registered state
    assign full      = (count_q == CNTBITS'(DEPTH));
    assign empty     = (count_q == CNTBITS'(0));
    assign overflow  = overflow_q;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = idx_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign mem_raddr = cpu_widx;

    // A pop frees a slot in the same cycle, so a store into a full buffer still fits
    assign pop  = (state_q == ST_REQ) && mem_ack;
    assign push = cpu_memwrite && (!full || pop);
    assign drop = cpu_memwrite && full && !pop;

    // Pointer, count, valid, overflow and drain-FSM next state
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTRBITS'(1);
        end
        // Set after the clear: on a full buffer tail and head coincide
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTRBITS'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNTBITS'(1);
            2'b01:   count_d = count_q - CNTBITS'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: if (push) state_d = ST_REQ;
            ST_REQ:  if (pop && (count_d == CNTBITS'(0))) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry payload written at the tail on an accepted store
    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        if (push) begin
            idx_d[tail_q]  = cpu_widx;
            data_d[tail_q] = cpu_wdata;
        end
    end

    // Load forwarding: scan oldest to youngest so the youngest match wins
    always_comb begin
        logic [PTRBITS-1:0] slot;
        slot      = '0;
        cpu_rdata = mem_rdata;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_q + PTRBITS'(i);
            if (valid_q[slot] && (idx_q[slot] == cpu_widx)) begin
                cpu_rdata = data_q[slot];
            end
        end
    end

    // Control state with synchronous reset; pending entries are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    // Entry payload storage; qualified by valid bits, so no reset needed
    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios followed by
// random traffic, checked against a queue-based model of the buffer.
module tb_dmem_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_memwrite;
    logic [31:0] cpu_rdata;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [13:0] mem_raddr;
    logic [31:0] mem_rdata;

    dmem_store_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_memwrite (cpu_memwrite),
        .cpu_rdata    (cpu_rdata),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] idx;
        logic [31:0] data;
    } ent_t;

    // Model: queue of pending writes in program order plus a sticky overflow bit
    ent_t q[$];
    logic m_ovf;

    int checks;
    int errors;

    // Snapshot of DUT outputs taken mid-cycle by cyc()
    logic        s_req, s_full, s_empty, s_ovf;
    logic [13:0] s_addr;
    logic [31:0] s_wdata, s_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] widx(input logic [31:0] a);
        return a[15:2];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] rd);
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].idx == widx(a)) return q[i].data;
        end
        return rd;
    endfunction

    // One clock cycle: drive, check mid-cycle against the model, then advance it
    task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rd, input logic r);
        logic exp_req;
        logic do_pop;
        logic do_push;
        cpu_memwrite = we;
        cpu_addr     = addr;
        cpu_wdata    = wd;
        mem_ack      = ack;
        mem_rdata    = rd;
        rst          = r;
        @(negedge clk);
        s_req   = mem_req;
        s_full  = full;
        s_empty = empty;
        s_ovf   = overflow;
        s_addr  = mem_addr;
        s_wdata = mem_wdata;
        s_rdata = cpu_rdata;
        exp_req = (q.size() != 0);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("mem_raddr", 32'(mem_raddr), 32'(widx(addr)));
        chk("cpu_rdata", cpu_rdata, model_load(addr, rd));
        if (exp_req) begin
            chk("mem_addr", 32'(mem_addr), 32'(q[0].idx));
            chk("mem_wdata", mem_wdata, q[0].data);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop  = exp_req && ack;
            do_push = we && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{idx: widx(addr), data: wd});
            else if (we) m_ovf = 1'b1;
        end
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;
        rst = 1'b1; cpu_memwrite = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state; loads fall through to memory
        cyc(0, 32'h40, 0, 0, 32'h1234_5678, 0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_load", s_rdata, 32'h1234_5678);

        // Single store, ack delayed three cycles
        cyc(1, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 0);
        chk("t2_req_latency", 32'(s_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'h0, 0, 0, 32'h0, 0);
            chk("t2_addr", 32'(s_addr), 32'h10);
            chk("t2_wdata", s_wdata, 32'hDEAD_BEEF);
        end
        cyc(0, 32'h0, 0, 1, 32'h0, 0);
        chk("t2_addr_ack", 32'(s_addr), 32'h10);
        cyc(0, 32'h0, 0, 0, 32'h0, 0);
        chk("t2_empty_after", 32'(s_empty), 32'd1);

        // Youngest-match forwarding and in-order drain of duplicates
        cyc(1, 32'h40, 32'h11, 0, 32'h99, 0);
        cyc(1, 32'h40, 32'h22, 0, 32'h99, 0);
        chk("t3_fwd_old", s_rdata, 32'h11);
        cyc(0, 32'h40, 0, 0, 32'h99, 0);
        chk("t3_fwd_young", s_rdata, 32'h22);
        cyc(0, 32'h40, 0, 1, 32'h99, 0);
        chk("t3_drain0", s_wdata, 32'h11);
        chk("t3_fwd_during_pop", s_rdata, 32'h22);
        cyc(0, 32'h40, 0, 1, 32'h99, 0);
        chk("t3_drain1", s_wdata, 32'h22);
        cyc(0, 32'h40, 0, 0, 32'h99, 0);
        chk("t3_after_drain", s_rdata, 32'h99);

        // Fill, then a dropped store sets overflow
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'hA0 + 32'(i), 0, 32'h0, 0);
        cyc(1, 32'h10, 32'h55, 0, 32'h0, 0);
        chk("t4_full", 32'(s_full), 32'd1);
        cyc(0, 32'h10, 0, 0, 32'h0, 0);
        chk("t4_ovf", 32'(s_ovf), 32'd1);
        chk("t4_dropped_load", s_rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 32'h0, 0, 1, 32'h0, 0);
            chk("t4_drain", s_wdata, 32'hA0 + 32'(i));
        end
        cyc(0, 32'h0, 0, 0, 32'h0, 0);
        chk("t4_ovf_sticky", 32'(s_ovf), 32'd1);
        cyc(0, 32'h0, 0, 0, 32'h0, 1);

        // Store into a full buffer alongside an ack is accepted
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'hB0 + 32'(i), 0, 32'h0, 0);
        cyc(1, 32'h20, 32'h77, 1, 32'h0, 0);
        chk("t5_full_pre", 32'(s_full), 32'd1);
        cyc(0, 32'h0, 0, 0, 32'h0, 0);
        chk("t5_full_post", 32'(s_full), 32'd1);
        chk("t5_no_ovf", 32'(s_ovf), 32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 32'h0, 0, 1, 32'h0, 0);
            chk("t5_drain", s_wdata, 32'hB0 + 32'(i));
        end
        cyc(0, 32'h0, 0, 1, 32'h0, 0);
        chk("t5_last_data", s_wdata, 32'h77);
        chk("t5_last_addr", 32'(s_addr), 32'h8);

        // Reset mid-handshake discards pending writes
        for (int i = 0; i < 3; i++) cyc(1, 32'h100 + 32'(i * 4), 32'hC0 + 32'(i), 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 0, 32'h0, 1);
        chk("t6_req_before", 32'(s_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 32'h100, 0, 1, 32'h5A5A_0000 + 32'(i), 0);
            chk("t6_req", 32'(s_req), 32'd0);
            chk("t6_empty", 32'(s_empty), 32'd1);
            chk("t6_load", s_rdata, 32'h5A5A_0000 + 32'(i));
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            ra = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            cyc(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, ra, $urandom,
                ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, $urandom,
                ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write store buffer between the pipelined core's M-stage data port and the data memory.
- Stores are accepted in one cycle into a small FIFO and drained to the backing memory over a req/ack handshake, so a slow memory write does not hold up the pipeline.
- Loads are answered combinationally in the same cycle. The youngest buffered store to the same word wins; otherwise the load reads from the backing memory.

Parameters:
- WIDTH, 32, data and address width
- DMEMDEPTH, 14, word-index width of the backing memory
- DEPTH, 4, number of buffer entries; must be a power of 2
- PTRBITS, 2, log2(DEPTH)

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- cpu_addr  input  WIDTH  byte address from the M stage (ALU result)
- cpu_wdata  input  WIDTH  store data
- cpu_memwrite  input  1  store request this cycle
- cpu_rdata  output  WIDTH  load data, combinational
- full  output  1  buffer holds DEPTH entries
- empty  output  1  buffer holds 0 entries
- overflow  output  1  sticky: a store was dropped
- mem_req  output  1  write request to the backing memory
- mem_addr  output  DMEMDEPTH  write word index (head entry)
- mem_wdata  output  WIDTH  write data (head entry)
- mem_ack  input  1  backing memory accepted the head write this cycle
- mem_raddr  output  DMEMDEPTH  read word index
- mem_rdata  input  WIDTH  read data from the backing memory, combinational

Behaviour:
- Word index is cpu_addr[DMEMDEPTH+1:2]. Byte offset bits [1:0] are ignored. Only word accesses are supported.
- Storage consists of:
  - DEPTH entries of {valid, word index, data};
  - head and tail pointers of PTRBITS bits each, wrapping modulo DEPTH;
  - a count of PTRBITS+1 bits, ranging 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0). Both are derived from registered state.
- Reset (any cycle, including mid-handshake):
  - all valid bits, head, tail, count and overflow are cleared;
  - pending entries are discarded and are not written to memory;
  - after the edge: mem_req=0, empty=1, full=0, overflow=0.
  - mem_addr and mem_wdata are don't-care while mem_req=0.
- Drain FSM has two states, IDLE and REQ:
  - IDLE: mem_req=0. Moves to REQ on the edge after the first entry is enqueued.
  - REQ: mem_req=1; mem_addr and mem_wdata show the head entry and stay stable until mem_ack.
  - On mem_ack in REQ: the head entry is popped (valid cleared, head+1, count-1). The FSM stays in REQ if entries remain, otherwise it returns to IDLE.
  - mem_ack while in IDLE is ignored.
  - Back-to-back acks drain one entry per cycle.
- Enqueue: if cpu_memwrite=1 and (full=0 or a pop occurs the same cycle), the entry is written at tail (valid=1, tail+1, count+1).
  - Simultaneous enqueue and pop leaves count unchanged.
  - Enqueue into an empty buffer is not visible on mem_req until the following cycle (1-cycle latency).
- Overflow: if cpu_memwrite=1, full=1 and there is no pop that cycle, the store is dropped and overflow is set. overflow stays set until rst.
- Load path (purely combinational from current registered state):
  - mem_raddr = word index of cpu_addr.
  - All valid entries are searched from youngest (tail-1) to oldest (head). The first entry whose index matches supplies cpu_rdata.
  - If no entry matches, cpu_rdata = mem_rdata.
  - A store presented in the same cycle as a load to the same address is not forwarded; it becomes visible from the next cycle.
  - An entry popped on this cycle's edge is still forwarded during this cycle.
- Ordering: writes reach memory strictly in program order. Duplicate addresses are not coalesced.
- A non-store cycle with cpu_memwrite=0 has no effect on the buffer.

Test Plan:
- Reset → empty=1, full=0, mem_req=0, overflow=0; cpu_rdata equals mem_rdata for any address.
- Store addr 0x40 data 0xDEADBEEF, mem_ack held low 3 cycles then pulsed → mem_req rises the next cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF stable for 4 cycles; empty=1 after the ack edge.
- Store 0x40=0x11, then next cycle store 0x40=0x22, mem_ack low; load 0x40 with mem_rdata=0x99 → cpu_rdata=0x22. Acks then drain 0x11 first, then 0x22; after drain cpu_rdata=0x99.
- Four stores to 0x0,0x4,0x8,0xC with mem_ack low → full=1. A fifth store 0x10=0x55 with no ack → dropped, overflow=1, count stays 4, mem_wdata sequence excludes 0x55.
- Full buffer, store 0x20=0x77 in the same cycle as mem_ack → accepted, full stays 1, overflow stays 0, 0x77 drains last.
- Three entries buffered with mem_req=1, rst asserted one cycle mid-handshake → next cycle mem_req=0, empty=1, no further writes issued, loads return mem_rdata.
